// File: rtl/sync_pulse_gen_if.sv
// Sequencer-to-pulse-generator link: pulse request/code/abort in, status and envelope out.
interface sync_pulse_gen_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [2:0]       code;
   logic             abort;
   logic             ready;
   logic             envelope;
   logic [WIDTH-1:0] pulse_len;
   logic             done;

   modport master (
      output start, code, abort,
      input  ready, envelope, pulse_len, done
   );

   modport slave (
      input  start, code, abort,
      output ready, envelope, pulse_len, done
   );
endinterface

// File: rtl/sync_pulse_gen.sv
// Optical sync-pulse transmitter: one envelope pulse of BASE_TICKS + code*STEP_TICKS cycles,
// followed by an enforced low gap of GAP_TICKS cycles, with a done strobe on return to idle.
module sync_pulse_gen #(
   parameter int unsigned WIDTH      = 16,
   parameter int unsigned BASE_TICKS = 3000,
   parameter int unsigned STEP_TICKS = 500,
   parameter int unsigned GAP_TICKS  = 100
) (
   input logic             clk,
   input logic             reset,
   sync_pulse_gen_if.slave bus
);

   localparam int unsigned XW = WIDTH + 3;
   localparam logic [WIDTH-1:0] GAP_LOAD = WIDTH'(GAP_TICKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] len_q, len_nxt;
   logic             env_q, env_nxt;
   logic             done_q, done_nxt;
   logic             ready_q, ready_nxt;
   logic [XW-1:0]    w_ext;
   logic [WIDTH-1:0] w;

   // Programmed width: widened sum, saturated to the counter range, zero clamped to one tick.
   always_comb begin
      w_ext = XW'(BASE_TICKS) + XW'(bus.code) * XW'(STEP_TICKS);
      w     = (|w_ext[XW-1:WIDTH]) ? '1 : w_ext[WIDTH-1:0];
      if (w == '0) begin
         w = WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         cnt     <= '0;
         len_q   <= '0;
         env_q   <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         len_q   <= len_nxt;
         env_q   <= env_nxt;
         done_q  <= done_nxt;
         ready_q <= ready_nxt;
      end
   end

   // Next state; abort beats start in IDLE and truncates PULSE, but the gap always runs in full.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len_q;
      env_nxt   = env_q;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            env_nxt = 1'b0;
            if (bus.start && !bus.abort) begin
               state_nxt = PULSE;
               len_nxt   = w;
               cnt_nxt   = w - WIDTH'(1);
               env_nxt   = 1'b1;
            end
         end
         PULSE: begin
            if (bus.abort || cnt == '0) begin
               state_nxt = GAP;
               cnt_nxt   = GAP_LOAD;
               env_nxt   = 1'b0;
            end else begin
               cnt_nxt = cnt - WIDTH'(1);
            end
         end
         GAP: begin
            env_nxt = 1'b0;
            if (cnt == '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - WIDTH'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            env_nxt   = 1'b0;
         end
      endcase

      ready_nxt = (state_nxt == IDLE);
   end

   assign bus.ready     = ready_q;
   assign bus.envelope  = env_q;
   assign bus.pulse_len = len_q;
   assign bus.done      = done_q;

endmodule
